timer_ctrl: RTL and testbench



---
 rtl/timer_ctrl_if.sv | 23 ++
 rtl/timer_ctrl.sv | 166 ++++++++++++++++
 tb/tb_timer_ctrl.sv | 291 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/timer_ctrl_if.sv
// Counter-side bundle between timer_ctrl (master) and the up/down counter (slave).
// Signal names follow the timer's point of view: _o leaves the timer, _i enters it.
interface timer_ctrl_if #(
  parameter int WIDTH = 16
);
  logic             cnt_clear_o;
  logic             cnt_en_o;
  logic             cnt_load_o;
  logic             cnt_down_o;
  logic [WIDTH-1:0] cnt_d_o;
  logic [WIDTH-1:0] cnt_q_i;
  logic             cnt_overflow_i;

  modport master (
    output cnt_clear_o, cnt_en_o, cnt_load_o, cnt_down_o, cnt_d_o,
    input  cnt_q_i, cnt_overflow_i
  );

  modport slave (
    input  cnt_clear_o, cnt_en_o, cnt_load_o, cnt_down_o, cnt_d_o,
    output cnt_q_i, cnt_overflow_i
  );
endinterface

// File: rtl/timer_ctrl.sv
// Timer control stage: prescales the clock, steers an external up/down counter and flags compare match.
// Optional prescaler enabled by defining TIMER_CTRL_PRESCALER_EN; otherwise every RUN cycle is a tick.
module timer_ctrl #(
  parameter int WIDTH       = 16,
  parameter int PRESC_WIDTH = 8
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   start_i,
  input  logic                   stop_i,
  input  logic                   oneshot_i,
  input  logic                   down_i,
  input  logic [PRESC_WIDTH-1:0] presc_i,
  input  logic [WIDTH-1:0]       cmp_i,
  input  logic                   irq_ack_i,
  output logic                   busy_o,
  output logic                   match_o,
  output logic                   irq_o,
  output logic                   err_o,
  timer_ctrl_if.master           cnt_if
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ARM  = 2'd1,
    RUN  = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic             oneshot_q;
  logic             down_q;
  logic [WIDTH-1:0] cmp_q;
  logic             match_q;
  logic             irq_q, irq_d;
  logic             err_q, err_d;

  logic             cfg_load;
  logic             tick_raw;
  logic             tick;
  logic             hit;
  logic             clear_s;
  logic             load_s;
  logic             en_s;

  assign cfg_load = start_i & ~stop_i;

`ifdef TIMER_CTRL_PRESCALER_EN
  logic [PRESC_WIDTH-1:0] presc_q;
  logic [PRESC_WIDTH-1:0] presc_cnt_q, presc_cnt_d;

  assign tick_raw = (presc_cnt_q == presc_q);

  always_comb begin
    presc_cnt_d = presc_cnt_q;
    if (state_q == ARM) begin
      presc_cnt_d = '0;
    end else if (state_q == RUN) begin
      presc_cnt_d = tick_raw ? '0 : presc_cnt_q + 1'b1;
    end
  end
`else
  logic unused_presc;

  assign unused_presc = ^presc_i;
  assign tick_raw     = 1'b1;
`endif

  // NOTE: every signal assigned here gets a default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    state_d = state_q;
    irq_d   = irq_q;
    err_d   = err_q;
    tick    = 1'b0;
    hit     = 1'b0;
    clear_s = 1'b0;
    load_s  = 1'b0;
    en_s    = 1'b0;

    unique case (state_q)
      IDLE: ;
      ARM: begin
        clear_s = ~down_q;
        load_s  = down_q;
        state_d = RUN;
      end
      RUN: begin
        tick    = tick_raw;
        hit     = tick && (cnt_if.cnt_q_i == (down_q ? '0 : cmp_q));
        en_s    = tick & ~hit;
        // Rewind on match: up mode restarts from 0, down mode reloads cmp.
        clear_s = hit & ~down_q;
        load_s  = hit & down_q;
        if (hit && oneshot_q) begin
          state_d = IDLE;
        end
        if (cnt_if.cnt_overflow_i) begin
          err_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    if (hit) begin
      irq_d = 1'b1;
    end else if (irq_ack_i) begin
      irq_d = 1'b0;
    end

    // stop dominates start; a restart clears the error flag.
    if (stop_i) begin
      state_d = IDLE;
    end else if (start_i) begin
      state_d = ARM;
      err_d   = 1'b0;
    end
  end

  // NOTE: all state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk_i or posedge rst_i) begin
    // NOTE: reset is asynchronous and covers every register; there is no memory array to leave unreset.
    if (rst_i) begin
      state_q     <= IDLE;
      oneshot_q   <= 1'b0;
      down_q      <= 1'b0;
      cmp_q       <= '0;
      match_q     <= 1'b0;
      irq_q       <= 1'b0;
      err_q       <= 1'b0;
`ifdef TIMER_CTRL_PRESCALER_EN
      presc_q     <= '0;
      presc_cnt_q <= '0;
`endif
    end else begin
      state_q <= state_d;
      match_q <= hit;
      irq_q   <= irq_d;
      err_q   <= err_d;
      if (cfg_load) begin
        oneshot_q <= oneshot_i;
        down_q    <= down_i;
        cmp_q     <= cmp_i;
`ifdef TIMER_CTRL_PRESCALER_EN
        presc_q   <= presc_i;
`endif
      end
`ifdef TIMER_CTRL_PRESCALER_EN
      presc_cnt_q <= presc_cnt_d;
`endif
    end
  end

  assign cnt_if.cnt_clear_o = clear_s;
  assign cnt_if.cnt_load_o  = load_s;
  assign cnt_if.cnt_en_o    = en_s;
  assign cnt_if.cnt_down_o  = down_q;
  assign cnt_if.cnt_d_o     = cmp_q;

  assign busy_o  = (state_q == ARM) || (state_q == RUN);
  assign match_o = match_q;
  assign irq_o   = irq_q;
  assign err_o   = err_q;

  strobe_onehot_a : assert property (@(posedge clk_i) disable iff (rst_i)
    $onehot0({clear_s, load_s, en_s}));

endmodule

// File: tb/tb_timer_ctrl.sv
// Scoreboard bench for timer_ctrl: a behavioural counter closes the loop and a monitor checks match timing.
// Expected match edges follow the period formula; prescaler values collapse to 0 when TIMER_CTRL_PRESCALER_EN is undefined.
module tb_timer_ctrl;

  localparam int WIDTH       = 16;
  localparam int PRESC_WIDTH = 8;

  logic                   clk = 1'b0;
  logic                   rst = 1'b1;
  logic                   start_i = 1'b0;
  logic                   stop_i = 1'b0;
  logic                   oneshot_i = 1'b0;
  logic                   down_i = 1'b0;
  logic [PRESC_WIDTH-1:0] presc_i = '0;
  logic [WIDTH-1:0]       cmp_i = '0;
  logic                   irq_ack_i = 1'b0;
  logic                   busy_o, match_o, irq_o, err_o;
  logic                   force_ovf = 1'b0;
  logic [WIDTH-1:0]       model_q;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int exp_q[$];

  timer_ctrl_if #(.WIDTH(WIDTH)) cnt_if ();

  timer_ctrl #(.WIDTH(WIDTH), .PRESC_WIDTH(PRESC_WIDTH)) dut (
    .clk_i     (clk),
    .rst_i     (rst),
    .start_i   (start_i),
    .stop_i    (stop_i),
    .oneshot_i (oneshot_i),
    .down_i    (down_i),
    .presc_i   (presc_i),
    .cmp_i     (cmp_i),
    .irq_ack_i (irq_ack_i),
    .busy_o    (busy_o),
    .match_o   (match_o),
    .irq_o     (irq_o),
    .err_o     (err_o),
    .cnt_if    (cnt_if)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural up/down counter attached to the control stage.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                     model_q <= '0;
    else if (cnt_if.cnt_clear_o) model_q <= '0;
    else if (cnt_if.cnt_load_o)  model_q <= cnt_if.cnt_d_o;
    else if (cnt_if.cnt_en_o)    model_q <= cnt_if.cnt_down_o ? model_q - 1'b1 : model_q + 1'b1;
  end

  assign cnt_if.cnt_q_i        = model_q;
  assign cnt_if.cnt_overflow_i = force_ovf;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d want %0d (edge %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic int eff_presc(input int p);
`ifdef TIMER_CTRL_PRESCALER_EN
    return p;
`else
    return 0;
`endif
  endfunction

  // Monitor: every match pulse must correspond to the oldest pending expectation.
  always @(negedge clk) begin
    if (!rst) begin
      if (match_o) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL match_unexpected: got match at edge %0d want none", cyc);
        end else begin
          check("match_edge", cyc, exp_q.pop_front());
        end
      end
      check("strobe_onehot",
            ($countones({cnt_if.cnt_clear_o, cnt_if.cnt_load_o, cnt_if.cnt_en_o}) <= 1), 1);
    end
  end

  // Called just after a negedge; returns at the negedge inside the ARM cycle.
  task automatic do_start(input logic os, input logic dn, input int p, input int c, output int e);
    oneshot_i = os;
    down_i    = dn;
    presc_i   = PRESC_WIDTH'(p);
    cmp_i     = WIDTH'(c);
    start_i   = 1'b1;
    e         = cyc + 1;
    @(negedge clk);
    start_i   = 1'b0;
    oneshot_i = ~os;
    down_i    = ~dn;
    presc_i   = '1;
    cmp_i     = '1;
  endtask

  task automatic wait_to(input int n);
    while (cyc < n) @(negedge clk);
  endtask

  task automatic do_stop();
    stop_i = 1'b1;
    @(negedge clk);
    stop_i = 1'b0;
  endtask

  // Periodic up run; stop is sampled one edge after the n-th match.
  task automatic run_periodic(input int p, input int c, input int n, output int en_cnt);
    int e, per, first, s, m;
    do_start(1'b0, 1'b0, p, c, e);
    per   = (eff_presc(p) + 1) * (c + 1);
    first = e + 1 + per;
    s     = first + (n - 1) * per + 1;
    m     = first;
    while (m <= s) begin
      exp_q.push_back(m);
      m += per;
    end
    en_cnt = 0;
    while (cyc < s - 1) begin
      @(negedge clk);
      en_cnt += int'(cnt_if.cnt_en_o);
    end
    do_stop();
    check("busy_after_stop", busy_o, 0);
  endtask

  initial begin
    int e, e2, per, first, en_cnt;
    int seq[5] = '{0, 1, 2, 3, 0};

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_busy", busy_o, 0);
    check("rst_match", match_o, 0);
    check("rst_irq", irq_o, 0);
    check("rst_err", err_o, 0);
    check("rst_strobes", {cnt_if.cnt_clear_o, cnt_if.cnt_en_o, cnt_if.cnt_load_o, cnt_if.cnt_down_o}, 0);
    check("rst_d", cnt_if.cnt_d_o, 0);
    rst = 1'b0;
    @(negedge clk);
    check("idle_busy", busy_o, 0);

    // 1: up periodic, presc=0, cmp=3
    do_start(1'b0, 1'b0, 0, 3, e);
    exp_q.push_back(e + 5);
    exp_q.push_back(e + 9);
    exp_q.push_back(e + 13);
    check("t1_arm_clear", cnt_if.cnt_clear_o, 1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("t1_cnt_q", model_q, seq[i]);
      check("t1_busy", busy_o, 1);
    end
    wait_to(e + 13);
    check("t1_busy_late", busy_o, 1);
    do_stop();
    check("t1_idle", busy_o, 0);
    repeat (6) @(negedge clk);
    check("t1_queue_empty", exp_q.size(), 0);
    check("t1_irq", irq_o, 1);
    irq_ack_i = 1'b1;
    @(negedge clk);
    irq_ack_i = 1'b0;
    check("t1_irq_ack", irq_o, 0);

    // 2: down one-shot, presc=2, cmp=1
    do_start(1'b1, 1'b1, 2, 1, e);
    check("t2_arm_load", cnt_if.cnt_load_o, 1);
    check("t2_arm_d", cnt_if.cnt_d_o, 1);
    check("t2_down", cnt_if.cnt_down_o, 1);
    per = (eff_presc(2) + 1) * 2;
    exp_q.push_back(e + 1 + per);
    wait_to(e + 2 + per);
    check("t2_busy_done", busy_o, 0);
    check("t2_irq", irq_o, 1);
    check("t2_cnt_reloaded", model_q, 1);
    repeat (4) @(negedge clk);
    check("t2_queue_empty", exp_q.size(), 0);
    irq_ack_i = 1'b1;
    @(negedge clk);
    irq_ack_i = 1'b0;
    check("t2_irq_ack", irq_o, 0);

    // 3: irq ack collides with a match set, then ack alone clears
    do_start(1'b1, 1'b0, 1, 2, e);
    per   = (eff_presc(1) + 1) * 3;
    first = e + 1 + per;
    exp_q.push_back(first);
    wait_to(first - 1);
    check("t3_irq_before", irq_o, 0);
    irq_ack_i = 1'b1;
    @(negedge clk);
    check("t3_irq_set_wins", irq_o, 1);
    @(negedge clk);
    irq_ack_i = 1'b0;
    check("t3_irq_cleared", irq_o, 0);

    // 4a: stop+start together mid-RUN -> IDLE
    do_start(1'b0, 1'b0, 0, 5, e);
    wait_to(e + 2);
    start_i = 1'b1;
    stop_i  = 1'b1;
    cmp_i   = 16'd7;
    @(negedge clk);
    start_i = 1'b0;
    stop_i  = 1'b0;
    check("t4_stop_wins", busy_o, 0);
    en_cnt = 0;
    repeat (5) begin
      @(negedge clk);
      en_cnt += int'(cnt_if.cnt_en_o);
    end
    check("t4_no_en_after_stop", en_cnt, 0);
    check("t4_cnt_held", model_q, 2);

    // 4b: start alone mid-RUN restarts with new config
    do_start(1'b0, 1'b0, 0, 5, e);
    wait_to(e + 2);
    do_start(1'b0, 1'b0, 1, 2, e2);
    check("t4_restart_arm", cnt_if.cnt_clear_o, 1);
    check("t4_restart_d", cnt_if.cnt_d_o, 2);
    per   = (eff_presc(1) + 1) * 3;
    first = e2 + 1 + per;
    exp_q.push_back(first);
    exp_q.push_back(first + per);
    wait_to(first + per);
    do_stop();
    repeat (6) @(negedge clk);
    check("t4_queue_empty", exp_q.size(), 0);

    // 5: cmp=0 presc=0 -> match every cycle, no enable
    run_periodic(0, 0, 4, en_cnt);
    check("t5_no_en", en_cnt, 0);
    repeat (3) @(negedge clk);
    check("t5_queue_empty", exp_q.size(), 0);

    // 6: overflow sets err, restart clears it, async reset mid-count
    do_start(1'b0, 1'b0, 0, 9, e);
    wait_to(e + 2);
    force_ovf = 1'b1;
    @(negedge clk);
    force_ovf = 1'b0;
    check("t6_err_set", err_o, 1);
    @(negedge clk);
    check("t6_err_sticky", err_o, 1);
    do_start(1'b0, 1'b1, 0, 9, e2);
    check("t6_err_cleared", err_o, 0);
    wait_to(e2 + 2);
    force_ovf = 1'b1;
    @(negedge clk);
    force_ovf = 1'b0;
    check("t6_err_set2", err_o, 1);
    check("t6_busy_pre_rst", busy_o, 1);
    #2 rst = 1'b1;
    #1;
    check("t6_rst_busy", busy_o, 0);
    check("t6_rst_err", err_o, 0);
    check("t6_rst_match", match_o, 0);
    check("t6_rst_irq", irq_o, 0);
    check("t6_rst_strobes", {cnt_if.cnt_clear_o, cnt_if.cnt_en_o, cnt_if.cnt_load_o, cnt_if.cnt_down_o}, 0);
    check("t6_rst_d", cnt_if.cnt_d_o, 0);
    @(negedge clk);
    rst = 1'b0;
    repeat (15) @(negedge clk);
    check("t6_idle_after_rst", busy_o, 0);
    check("final_queue_empty", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout at edge %0d want completion", cyc);
    $fatal(1, "watchdog expired");
  end

endmodule
